// File: rtl/usr_xfer_nb.sv
// rtl/usr_xfer_nb.sv - universal shift register with autonomous n/S-step serial transfer
module usr_xfer_nb #(
    parameter int n = 8,
    parameter int S = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [n-1:0] data_in,
    input  logic [S-1:0] din_ser,
    input  logic [2:0]   op,
    input  logic         en,
    input  logic         start,
    output logic [n-1:0] data_out,
    output logic [S-1:0] dout_ser,
    output logic         busy,
    output logic         done
);
    localparam int STEPS = n / S;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {IDLE, XFER} state_t;

    state_t         state, state_nxt;
    logic [n-1:0]   q, q_nxt;
    logic           dir, dir_nxt;       // 0 = left, 1 = right
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           done_nxt;

    logic [n-1:0] shl_v, shr_v, rol_v, ror_v, asr_v;

    assign shl_v = {q[n-1-S:0], din_ser};
    assign shr_v = {din_ser, q[n-1:S]};
    assign rol_v = {q[n-1-S:0], q[n-1 -: S]};
    assign ror_v = {q[S-1:0], q[n-1:S]};
    assign asr_v = {{S{q[n-1]}}, q[n-1:S]};

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            q     <= '0;
            dir   <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            dir   <= dir_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // A valid start performs the first shift immediately, regardless of en
                if (start && (op == OP_SHL || op == OP_SHR)) begin
                    q_nxt   = (op == OP_SHL) ? shl_v : shr_v;
                    dir_nxt = (op == OP_SHR);
                    if (STEPS == 1) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = XFER;
                        cnt_nxt   = CW'(STEPS - 1);
                    end
                end else if (en) begin
                    case (op)
                        OP_HOLD: q_nxt = q;
                        OP_LOAD: q_nxt = data_in;
                        OP_SHL:  begin q_nxt = shl_v; dir_nxt = 1'b0; end
                        OP_SHR:  begin q_nxt = shr_v; dir_nxt = 1'b1; end
                        OP_ROL:  begin q_nxt = rol_v; dir_nxt = 1'b0; end
                        OP_ROR:  begin q_nxt = ror_v; dir_nxt = 1'b1; end
                        OP_ASR:  begin q_nxt = asr_v; dir_nxt = 1'b1; end
                        OP_CLR:  q_nxt = '0;
                        default: q_nxt = q;
                    endcase
                end
            end
            XFER: begin
                q_nxt   = dir ? shr_v : shl_v;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign data_out = q;
    assign busy     = (state == XFER);
    assign dout_ser = dir ? q[S-1:0] : q[n-1 -: S];
endmodule

// File: tb/tb_usr_xfer_nb.sv
// tb/tb_usr_xfer_nb.sv - directed self-checking bench for usr_xfer_nb (n=8, S=2)
module tb_usr_xfer_nb;
    localparam int N = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         clr;
    logic [N-1:0] data_in;
    logic [S-1:0] din_ser;
    logic [2:0]   op;
    logic         en;
    logic         start;
    logic [N-1:0] data_out;
    logic [S-1:0] dout_ser;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    usr_xfer_nb #(.n(N), .S(S)) dut (
        .clk      (clk),
        .clr      (clr),
        .data_in  (data_in),
        .din_ser  (din_ser),
        .op       (op),
        .en       (en),
        .start    (start),
        .data_out (data_out),
        .dout_ser (dout_ser),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [N-1:0] d, input logic [S-1:0] s);
        op = o; data_in = d; din_ser = s; en = 1'b1; start = 1'b0;
        tick();
        en = 1'b0; op = 3'b000;
    endtask

    task automatic manual(input string tag, input logic [2:0] o, input logic [S-1:0] s,
                          input logic [N-1:0] exp);
        do_op(3'b001, 8'hB4, 2'b00);
        do_op(o, 8'h00, s);
        check(tag, 32'(data_out), 32'(exp));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        clr = 1'b1; data_in = '0; din_ser = '0; op = 3'b000; en = 1'b0; start = 1'b0;
        tick();
        check("rst_q", 32'(data_out), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        clr = 1'b0;

        // 1: preload FF, then clr raised between edges acts only at the edge
        do_op(3'b001, 8'hFF, 2'b00);
        op = 3'b001; en = 1'b1; data_in = 8'hFF;
        #2 clr = 1'b1;
        #1;
        check("clr_between_edges", 32'(data_out), 32'hFF);
        tick();
        check("clr_q", 32'(data_out), 32'h00);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        clr = 1'b0; en = 1'b0; op = 3'b000;

        // 2: manual ops from 0xB4
        manual("ror", 3'b101, 2'b00, 8'h2D);
        manual("asr", 3'b110, 2'b00, 8'hED);
        manual("shl", 3'b010, 2'b11, 8'hD3);
        manual("shr", 3'b011, 2'b01, 8'h6D);
        manual("rol", 3'b100, 2'b00, 8'hD2);

        // 3 + 4: shl transfer with a load attempted while busy
        do_op(3'b001, 8'hB4, 2'b00);
        check("x3_dout0", 32'(dout_ser), 32'd2);
        start = 1'b1; op = 3'b010; din_ser = 2'b00;
        tick();
        start = 1'b0; op = 3'b001; en = 1'b1; data_in = 8'hFF;
        check("x3_q1", 32'(data_out), 32'hD0);
        check("x3_busy1", 32'(busy), 32'd1);
        check("x3_done1", 32'(done), 32'd0);
        check("x3_dout1", 32'(dout_ser), 32'd3);
        tick();
        check("x3_q2", 32'(data_out), 32'h40);
        check("x3_busy2", 32'(busy), 32'd1);
        check("x3_dout2", 32'(dout_ser), 32'd1);
        tick();
        check("x3_q3", 32'(data_out), 32'h00);
        check("x3_busy3", 32'(busy), 32'd1);
        check("x3_done3", 32'(done), 32'd0);
        check("x3_dout3", 32'(dout_ser), 32'd0);
        tick();
        en = 1'b0; op = 3'b000;
        check("x3_q4", 32'(data_out), 32'h00);
        check("x3_busy4", 32'(busy), 32'd0);
        check("x3_done4", 32'(done), 32'd1);
        tick();
        check("x3_done_pulse", 32'(done), 32'd0);

        // 5: shr transfer aborted by clr
        do_op(3'b001, 8'hB4, 2'b00);
        start = 1'b1; op = 3'b011; din_ser = 2'b11;
        tick();
        start = 1'b0; op = 3'b000;
        check("x5_q1", 32'(data_out), 32'hED);
        check("x5_dout1", 32'(dout_ser), 32'd1);
        tick();
        check("x5_q2", 32'(data_out), 32'hFB);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("x5_clr_q", 32'(data_out), 32'h00);
        check("x5_clr_busy", 32'(busy), 32'd0);
        check("x5_clr_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("x5_no_done", 32'(done), 32'd0);
        end
        start = 1'b1; op = 3'b011; din_ser = 2'b11;
        tick();
        start = 1'b0; op = 3'b000;
        check("x5_restart_busy", 32'(busy), 32'd1);
        tick(); tick(); tick();
        check("x5_restart_q", 32'(data_out), 32'hFF);
        check("x5_restart_done", 32'(done), 32'd1);

        // 6: start with non-shift op acts as manual ror
        do_op(3'b001, 8'hB4, 2'b00);
        start = 1'b1; op = 3'b101; en = 1'b1;
        tick();
        start = 1'b0; en = 1'b0; op = 3'b000;
        check("x6_ror_q", 32'(data_out), 32'h2D);
        check("x6_ror_busy", 32'(busy), 32'd0);
        check("x6_ror_done", 32'(done), 32'd0);
        tick();
        check("x6_ror_busy2", 32'(busy), 32'd0);
        check("x6_ror_done2", 32'(done), 32'd0);

        // 6: back-to-back transfers, second start in the done cycle
        start = 1'b1; op = 3'b010; din_ser = 2'b01;
        tick();
        start = 1'b0; op = 3'b000;
        tick(); tick(); tick();
        check("x6_a_q", 32'(data_out), 32'h55);
        check("x6_a_done", 32'(done), 32'd1);
        start = 1'b1; op = 3'b010; din_ser = 2'b10;
        tick();
        start = 1'b0; op = 3'b000;
        check("x6_b_q1", 32'(data_out), 32'h56);
        check("x6_b_busy1", 32'(busy), 32'd1);
        check("x6_b_done1", 32'(done), 32'd0);
        tick();
        check("x6_b_q2", 32'(data_out), 32'h5A);
        tick();
        check("x6_b_q3", 32'(data_out), 32'h6A);
        tick();
        check("x6_b_q4", 32'(data_out), 32'hAA);
        check("x6_b_done4", 32'(done), 32'd1);
        check("x6_b_busy4", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
